reg_pattern_checker_amisha: RTL and testbench

- Drive/check partner for the 8-bit resettable register.
- Writes an LFSR pattern onto the register's d input and reads each value back from q one cycle later.
- After the pattern run, pulses the register's reset and checks that q reads 0.
- Reports pass/fail, an error count and the first failing vector index; used as the built-in self-test for register instances.

---
 rtl/reg_pattern_checker_amisha.sv | 148 ++++++++++++++
 tb/tb_reg_pattern_checker_amisha.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pattern_checker_amisha.sv
`timescale 1ns/1ps
// Self-test driver for an 8-bit resettable register: LFSR write/readback, then a reset check; done 2*NUM_VEC+3 cycles after start.
// Optional REG_CHK_STOP_ON_ERR_EN ends the run at the first mismatch; start is ignored while busy.
module reg_pattern_checker_amisha #(
  parameter int         NUM_VEC = 16,
  parameter logic [7:0] SEED    = 8'h5A
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic       start_amisha,
  input  logic [7:0] q_amisha,
  output logic [7:0] d_amisha,
  output logic       dut_reset_amisha,
  output logic       busy_amisha,
  output logic       done_amisha,
  output logic       pass_amisha,
  output logic [7:0] err_cnt_amisha,
  output logic [7:0] first_fail_amisha
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPT,
    S_RST,
    S_RCHK,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_LAST    = 8'(NUM_VEC - 1);
  localparam logic [7:0] LP_RST_IDX = 8'(NUM_VEC);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_lfsr;
  logic [7:0] r_vec_idx;
  logic [7:0] r_d;
  logic [7:0] r_err_cnt;
  logic [7:0] r_first_fail;
  logic       r_dut_reset;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [7:0] w_lfsr_next;
  logic [7:0] w_err_inc;
  logic       w_capt_err;
  logic       w_rchk_err;

  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_capt_err  = (r_state == S_CAPT) && (q_amisha != r_lfsr);
  assign w_rchk_err  = (r_state == S_RCHK) && (q_amisha != 8'h00);
  assign w_err_inc   = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start_amisha) w_next_state = S_LOAD;
      S_LOAD: w_next_state = S_CAPT;
      S_CAPT: begin
`ifdef REG_CHK_STOP_ON_ERR_EN
        if (w_capt_err) w_next_state = S_DONE;
        else if (r_vec_idx == LP_LAST) w_next_state = S_RST;
        else w_next_state = S_LOAD;
`else
        if (r_vec_idx == LP_LAST) w_next_state = S_RST;
        else w_next_state = S_LOAD;
`endif
      end
      S_RST:  w_next_state = S_RCHK;
      S_RCHK: w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      r_lfsr       <= SEED;
      r_vec_idx    <= 8'd0;
      r_d          <= 8'h00;
      r_err_cnt    <= 8'd0;
      r_first_fail <= 8'hFF;
      r_dut_reset  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_amisha) begin
            r_d          <= SEED;
            r_lfsr       <= SEED;
            r_vec_idx    <= 8'd0;
            r_err_cnt    <= 8'd0;
            r_first_fail <= 8'hFF;
            r_busy       <= 1'b1;
            r_pass       <= 1'b0;
          end
        end
        S_CAPT: begin
          if (w_capt_err) begin
            r_err_cnt <= w_err_inc;
            if (r_first_fail == 8'hFF) r_first_fail <= r_vec_idx;
          end
          r_lfsr    <= w_lfsr_next;
          r_vec_idx <= r_vec_idx + 8'd1;
          if (w_next_state == S_LOAD) r_d <= w_lfsr_next;
          if (w_next_state == S_RST) r_dut_reset <= 1'b1;
        end
        S_RST: begin
          // d keeps the last vector while reset is high, so a register that ignores reset reads back non-zero
          r_dut_reset <= 1'b0;
          r_d         <= 8'h00;
        end
        S_RCHK: begin
          if (w_rchk_err) begin
            r_err_cnt <= w_err_inc;
            if (r_first_fail == 8'hFF) r_first_fail <= LP_RST_IDX;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_pass <= (r_err_cnt == 8'd0);
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign d_amisha          = r_d;
  assign dut_reset_amisha  = r_dut_reset;
  assign busy_amisha       = r_busy;
  assign done_amisha       = r_done;
  assign pass_amisha       = r_pass;
  assign err_cnt_amisha    = r_err_cnt;
  assign first_fail_amisha = r_first_fail;

endmodule

// File: tb/tb_reg_pattern_checker_amisha.sv
`timescale 1ns/1ps
// Bench for reg_pattern_checker_amisha with a behavioural 8-bit register that can stick q[0] low or ignore its reset.
module tb_reg_pattern_checker_amisha;

  localparam int         NV   = 4;
  localparam logic [7:0] SEED = 8'h5A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] q;
  logic [7:0] d;
  logic       dut_rst;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic [7:0] first_fail;

  logic [7:0] r_reg;
  logic       stuck0 = 1'b0;
  logic       ign_rst = 1'b0;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         done_at;
  int         rst_cnt;
  int         rst_at;

  reg_pattern_checker_amisha #(.NUM_VEC(NV), .SEED(SEED)) u_dut (
    .clk_amisha        (clk),
    .reset_amisha      (rst_n),
    .start_amisha      (start),
    .q_amisha          (q),
    .d_amisha          (d),
    .dut_reset_amisha  (dut_rst),
    .busy_amisha       (busy),
    .done_amisha       (done),
    .pass_amisha       (pass),
    .err_cnt_amisha    (err_cnt),
    .first_fail_amisha (first_fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut_rst && !ign_rst) r_reg <= 8'h00;
    else r_reg <= d;
  end
  assign q = stuck0 ? {r_reg[7:1], 1'b0} : r_reg;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Expected d trace: NV vectors (or fewer when the run stops early), then 00 after the reset pulse.
  task automatic push_expected(input int nvec, input bit with_zero);
    logic [7:0] l;
    exp_q.delete();
    l = SEED;
    for (int i = 0; i < nvec; i++) begin
      exp_q.push_back(l);
      l = lfsr_step(l);
    end
    if (with_zero) exp_q.push_back(8'h00);
  endtask

  // k counts negedges after the edge that samples start; d is recorded at each LOAD and after the reset pulse.
  task automatic do_run(input int max_cycles);
    obs_q.delete();
    done_at = -1;
    rst_cnt = 0;
    rst_at  = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if ((k % 2 == 0 && k < 2 * NV) || k == 2 * NV + 1) obs_q.push_back(d);
      if (dut_rst) begin
        rst_cnt++;
        rst_at = k;
      end
      if (done) begin
        done_at = k;
        break;
      end
    end
  endtask

  task automatic drain_trace(input string name);
    logic [7:0] e;
    logic [7:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s_d_trace: got nothing want %02h", name, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL %s_d_trace: got %02h want %02h", name, o, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({d, dut_rst, busy, done, pass, err_cnt, first_fail} !== {8'h00, 4'b0000, 8'h00, 8'hFF}) begin
      miscompares++;
      $display("FAIL reset_values: got d=%02h r=%b b=%b dn=%b p=%b e=%02h ff=%02h want 00/0/0/0/0/00/FF",
               d, dut_rst, busy, done, pass, err_cnt, first_fail);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loopback();
    stuck0 = 1'b0;
    ign_rst = 1'b0;
    push_expected(NV, 1'b1);
    do_run(40);
    drain_trace("loop");
    vectors++;
    if (done_at !== 2 * NV + 3) begin
      miscompares++;
      $display("FAIL loop_latency: got %0d want %0d", done_at, 2 * NV + 3);
    end
    vectors++;
    if (rst_cnt !== 1 || rst_at !== 2 * NV) begin
      miscompares++;
      $display("FAIL loop_dut_reset: got cnt=%0d at=%0d want cnt=1 at=%0d", rst_cnt, rst_at, 2 * NV);
    end
    vectors++;
    if ({pass, err_cnt, first_fail, busy} !== {1'b1, 8'h00, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL loop_result: got p=%b e=%02h ff=%02h b=%b want 1/00/FF/0", pass, err_cnt, first_fail, busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL loop_done_pulse: got done=%b pass=%b want 0/1", done, pass);
    end
  endtask

  task automatic test_stuck_bit();
    stuck0 = 1'b1;
    ign_rst = 1'b0;
`ifdef REG_CHK_STOP_ON_ERR_EN
    push_expected(3, 1'b0);
`else
    push_expected(NV, 1'b1);
`endif
    do_run(40);
    drain_trace("stuck");
    vectors++;
`ifdef REG_CHK_STOP_ON_ERR_EN
    if (done_at !== 7 || rst_cnt !== 0) begin
      miscompares++;
      $display("FAIL stuck_timing: got done=%0d rst=%0d want 7/0", done_at, rst_cnt);
    end
`else
    if (done_at !== 2 * NV + 3 || rst_cnt !== 1) begin
      miscompares++;
      $display("FAIL stuck_timing: got done=%0d rst=%0d want %0d/1", done_at, rst_cnt, 2 * NV + 3);
    end
`endif
    vectors++;
    if ({pass, err_cnt, first_fail} !== {1'b0, 8'd1, 8'd2}) begin
      miscompares++;
      $display("FAIL stuck_result: got p=%b e=%0d ff=%0d want 0/1/2", pass, err_cnt, first_fail);
    end
    stuck0 = 1'b0;
  endtask

  task automatic test_ignore_reset();
    stuck0 = 1'b0;
    ign_rst = 1'b1;
    do_run(40);
    vectors++;
    if (done_at !== 2 * NV + 3) begin
      miscompares++;
      $display("FAIL ignrst_latency: got %0d want %0d", done_at, 2 * NV + 3);
    end
    vectors++;
    if ({pass, err_cnt, first_fail} !== {1'b0, 8'd1, 8'(NV)}) begin
      miscompares++;
      $display("FAIL ignrst_result: got p=%b e=%0d ff=%0d want 0/1/%0d", pass, err_cnt, first_fail, NV);
    end
    ign_rst = 1'b0;
  endtask

  task automatic test_async_abort();
    int seen_done;
    seen_done = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({d, dut_rst, busy, done, pass, err_cnt, first_fail} !== {8'h00, 4'b0000, 8'h00, 8'hFF}) begin
      miscompares++;
      $display("FAIL abort_values: got d=%02h r=%b b=%b dn=%b p=%b e=%02h ff=%02h want 00/0/0/0/0/00/FF",
               d, dut_rst, busy, done, pass, err_cnt, first_fail);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    vectors++;
    if (seen_done !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: got done pulses=%0d busy=%b want 0/0", seen_done, busy);
    end
  endtask

  task automatic test_start_held();
    int n_done;
    int t_first;
    int t_second;
    logic b11;
    logic b12;
    n_done = 0;
    t_first = -1;
    t_second = -1;
    b11 = 1'bx;
    b12 = 1'bx;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 2 * NV + 3) b11 = busy;
      if (k == 2 * NV + 4) b12 = busy;
      if (done) begin
        n_done++;
        if (n_done == 1) t_first = k;
        if (n_done == 2) t_second = k;
      end
    end
    start = 1'b0;
    vectors++;
    if (n_done !== 2 || t_first !== 2 * NV + 3 || t_second !== 4 * NV + 7) begin
      miscompares++;
      $display("FAIL held_done: got n=%0d t=%0d,%0d want 2 at %0d,%0d", n_done, t_first, t_second,
               2 * NV + 3, 4 * NV + 7);
    end
    vectors++;
    if (b11 !== 1'b0 || b12 !== 1'b1) begin
      miscompares++;
      $display("FAIL held_busy: got %b,%b want 0,1", b11, b12);
    end
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL held_drain: got busy=%b pass=%b want 0/1", busy, pass);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_stuck_bit();
    test_ignore_reset();
    test_async_abort();
    test_loopback();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
